// File: rtl/controle_cronometro.sv
// Stopwatch run/pause/lap/clear controller: button debounce, mode FSM, tenth-second
// prescaler and live/lap display mux. Optional build macro: CRONO_SATURACAO_EN (stop at 999.9).

module crono_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] stable_cnt;

  // The level only moves after DEB_CYCLES consecutive synchronized samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DEB_LAST) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DW'(1);
      end
    end
  end

  assign press = level & ~level_d;
endmodule

module controle_cronometro #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 10,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_volta,
  input  logic [9:0] cont_seg,
  input  logic [3:0] cont_dec,
  output logic       tick_dec,
  output logic       cont_clr,
  output logic [9:0] disp_seg,
  output logic [3:0] disp_dec,
  output logic [1:0] estado
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ZERADO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    VOLTA    = 2'b11
  } estado_t;

  estado_t       state;
  estado_t       state_nx;
  logic          press_start;
  logic          press_volta;
  logic          running;
  logic          saturado;
  logic          start_bloq;
  logic          lap_load;
  logic          clr_nx;
  logic [PW-1:0] presc;
  logic [9:0]    lap_seg;
  logic [3:0]    lap_dec;

  crono_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (press_start)
  );

  crono_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_volta (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_volta),
    .press (press_volta)
  );

  assign running = (state == CONTANDO) || (state == VOLTA);

`ifdef CRONO_SATURACAO_EN
  logic no_limite;
  assign no_limite  = (cont_seg == 10'd999) && (cont_dec == 4'd9);
  assign saturado   = running && no_limite;
  assign start_bloq = no_limite;
`else
  assign saturado   = 1'b0;
  assign start_bloq = 1'b0;
`endif

  // press_*, tick_dec and cont_clr are single-cycle pulses with no backpressure:
  // the receiver must act in the cycle the pulse is high.
  always_comb begin
    state_nx = state;
    lap_load = 1'b0;
    clr_nx   = 1'b0;
    case (state)
      ZERADO: begin
        if (press_start) state_nx = CONTANDO;
      end
      CONTANDO: begin
        if (saturado || press_start) begin
          state_nx = PAUSADO;
        end else if (press_volta) begin
          state_nx = VOLTA;
          lap_load = 1'b1;
        end
      end
      VOLTA: begin
        if (saturado || press_start) state_nx = PAUSADO;
        else if (press_volta)        state_nx = CONTANDO;
      end
      PAUSADO: begin
        if (press_start && !start_bloq) begin
          state_nx = CONTANDO;
        end else if (press_volta) begin
          state_nx = ZERADO;
          clr_nx   = 1'b1;
        end
      end
      default: state_nx = ZERADO;
    endcase
  end

  // Prescaler phase survives VOLTA<->CONTANDO; any non-running state drops the partial tenth.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ZERADO;
      presc    <= '0;
      cont_clr <= 1'b0;
      lap_seg  <= '0;
      lap_dec  <= '0;
      disp_seg <= '0;
      disp_dec <= '0;
    end else begin
      state    <= state_nx;
      cont_clr <= clr_nx;
      if (!running || presc == TICK_LAST) presc <= '0;
      else                                presc <= presc + PW'(1);
      if (lap_load) begin
        lap_seg <= cont_seg;
        lap_dec <= cont_dec;
      end
      if (state == VOLTA) begin
        disp_seg <= lap_seg;
        disp_dec <= lap_dec;
      end else begin
        disp_seg <= cont_seg;
        disp_dec <= cont_dec;
      end
    end
  end

  assign tick_dec = running && (presc == TICK_LAST) && !saturado;
  assign estado   = state;
endmodule

// File: tb/tb_controle_cronometro.sv
// Bench for controle_cronometro: bench-side counter, press schedule derived from button
// hold times, and an event-level reference model checked every cycle.

module tb_controle_cronometro;
  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef CRONO_SATURACAO_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset block
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_volta = 1'b0;
  logic [9:0] cont_seg = '0;
  logic [3:0] cont_dec = '0;
  logic       tick_dec;
  logic       cont_clr;
  logic [9:0] disp_seg;
  logic [3:0] disp_dec;
  logic [1:0] estado;

  always #5 clk = ~clk;

  controle_cronometro #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_volta (btn_volta),
    .cont_seg  (cont_seg),
    .cont_dec  (cont_dec),
    .tick_dec  (tick_dec),
    .cont_clr  (cont_clr),
    .disp_seg  (disp_seg),
    .disp_dec  (disp_dec),
    .estado    (estado)
  );

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // scheduled press events: edge at which the FSM acts, and kind (0 start, 1 volta)
  int press_q_edge[$];
  int press_q_kind[$];

  // reference model (counts held as total tenths 0..9999)
  int m_state = 0;
  int m_run = 0;
  int m_lap = 0;
  int m_disp = 0;
  bit m_clr = 1'b0;

  // bench-side stopwatch counter and values seen just before the coming edge
  int   env_cnt = 0;
  bit   sv_reset = 1'b1;
  int   sv_cnt = 0;
  logic d_tick = 1'b0;
  logic d_clr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  // One clock cycle: advance environment and model across the edge, drive inputs, check.
  task automatic step(input bit r, input bit bs, input bit bv);
    bit ps, pv, run, at_max, sat, exp_tick;
    int nstate;
    @(negedge clk);
    edge_n++;
    if (sv_reset || d_clr === 1'b1) env_cnt = 0;
    else if (d_tick === 1'b1)       env_cnt = (env_cnt + 1) % 10000;

    ps = 1'b0;
    pv = 1'b0;
    while (press_q_edge.size() > 0 && press_q_edge[0] <= edge_n) begin
      if (press_q_edge[0] == edge_n) begin
        if (press_q_kind[0] == 0) ps = 1'b1;
        else                      pv = 1'b1;
      end
      void'(press_q_edge.pop_front());
      void'(press_q_kind.pop_front());
    end

    if (sv_reset) begin
      m_state = 0; m_run = 0; m_lap = 0; m_disp = 0; m_clr = 1'b0;
    end else begin
      run    = (m_state == 1) || (m_state == 3);
      at_max = (sv_cnt == 9999);
      sat    = SAT && run && at_max;
      m_disp = (m_state == 3) ? m_lap : sv_cnt;
      m_clr  = 1'b0;
      nstate = m_state;
      case (m_state)
        0: if (ps) nstate = 1;
        1: if (sat || ps) nstate = 2;
           else if (pv) begin nstate = 3; m_lap = sv_cnt; end
        3: if (sat || ps) nstate = 2;
           else if (pv) nstate = 1;
        default: if (ps && !(SAT && at_max)) nstate = 1;
                 else if (pv) begin nstate = 0; m_clr = 1'b1; end
      endcase
      m_run   = run ? m_run + 1 : 0;
      m_state = nstate;
    end

    reset     = r;
    btn_start = bs;
    btn_volta = bv;
    cont_seg  = 10'(env_cnt / 10);
    cont_dec  = 4'(env_cnt % 10);
    #1;
    run      = (m_state == 1) || (m_state == 3);
    sat      = SAT && run && (env_cnt == 9999);
    exp_tick = run && (m_run % DIV == DIV - 1) && !sat;
    chk("estado",   32'(estado),   m_state);
    chk("tick_dec", 32'(tick_dec), 32'(exp_tick));
    chk("cont_clr", 32'(cont_clr), 32'(m_clr));
    chk("disp_seg", 32'(disp_seg), m_disp / 10);
    chk("disp_dec", 32'(disp_dec), m_disp % 10);
    sv_reset = r;
    sv_cnt   = env_cnt;
    d_tick   = tick_dec;
    d_clr    = cont_clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // kind: 0 start, 1 volta, 2 both. A hold of at least DEB cycles is one press,
  // acted on DEB+3 edges after the button rises.
  task automatic hold(input int kind, input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin
      step(1'b0, kind != 1, kind != 0);
      if (i == 0 && hi >= DEB) begin
        if (kind != 1) begin press_q_edge.push_back(edge_n + DEB + 3); press_q_kind.push_back(0); end
        if (kind != 0) begin press_q_edge.push_back(edge_n + DEB + 3); press_q_kind.push_back(1); end
      end
    end
    idle(lo);
  endtask

  task automatic preload(input int t);
    env_cnt  = t;
    sv_cnt   = t;
    cont_seg = 10'(t / 10);
    cont_dec = 4'(t % 10);
  endtask

  initial begin
    int kind;
    // reset, then volta ignored while cleared
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    hold(1, 20, DEB + 3);
    // start held: one press, ticks every DIV cycles; short glitches are rejected
    hold(0, 10, DEB + 3);
    for (int i = 0; i < 6; i++)
      hold($urandom_range(0, 1), $urandom_range(1, DEB - 1), DEB + 2 + $urandom_range(0, 5));
    // lap freeze and release
    preload(123);
    hold(1, DEB + 2, DEB + 3);
    idle(25);
    hold(1, DEB + 2, DEB + 3);
    idle(15);
    // pause, clear, run, simultaneous presses
    hold(0, DEB + 2, DEB + 3);
    idle(20);
    hold(1, DEB + 2, DEB + 3);
    idle(5);
    hold(0, DEB + 2, DEB + 3);
    idle(12);
    hold(2, DEB + 2, DEB + 3);
    idle(10);
    // end of range: saturation or wrap depending on build
    preload(9997);
    hold(0, DEB + 2, DEB + 3);
    idle(40);
    hold(0, DEB + 2, DEB + 3);
    idle(10);
    hold(1, DEB + 2, DEB + 3);
    idle(5);
    // randomized press mix
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0 && (m_state == 0 || m_state == 2))
        preload($urandom_range(9990, 9999));
      kind = $urandom_range(0, 3);
      if (kind == 3) hold($urandom_range(0, 1), $urandom_range(1, DEB - 1), DEB + 2 + $urandom_range(0, 6));
      else           hold(kind, $urandom_range(DEB, DEB + 8), DEB + 2 + $urandom_range(0, 20));
    end
    // steer into lap mode, then reset mid-operation
    for (int t = 0; t < 8; t++) begin
      if (m_state == 0)                          hold(0, DEB + 2, DEB + 3);
      else if (m_state == 1)                     hold(1, DEB + 2, DEB + 3);
      else if (m_state == 2 && SAT && env_cnt == 9999) hold(1, DEB + 2, DEB + 3);
      else if (m_state == 2)                     hold(0, DEB + 2, DEB + 3);
    end
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
